// File: rtl/onchip_ram_avmm_param.sv
// Avalon-MM single-port on-chip RAM slave: byte-lane writes, read latency 1 or 2,
// clock-enable stalls and an optional post-reset zero-fill pass before accepting commands.
module onchip_ram_avmm_param #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 38400,
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    input  logic                reset_req,
    input  logic                freeze,
    output logic                waitrequest,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic              en;
    logic              in_clear;
    logic              addr_ok;
    logic              acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] fill_addr_reg;

    assign en          = clken & ~reset_req;
    assign in_clear    = (state_reg == ST_CLEAR);
    assign waitrequest = in_clear | ~en;
    assign init_done   = ~in_clear;
    assign addr_ok     = ({1'b0, address} < DEPTH_LIM);
    assign acc         = chipselect & ~waitrequest;
    assign wr_acc      = acc & write;
    assign rd_acc      = acc & read & ~write;

    // Fill sequencer: one word per enabled cycle, parks in READY until the next reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            fill_addr_reg <= '0;
        end else if (en && in_clear) begin
            if (fill_addr_reg == LAST_ADDR) begin
                state_reg <= ST_READY;
            end else begin
                fill_addr_reg <= fill_addr_reg + 1'b1;
            end
        end
    end

    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [NB-1:0]     mem_be;

    // Out-of-range addresses are steered to word 0 so the array is never indexed past DEPTH;
    // the write is suppressed and the read result is masked to zero downstream.
    always_comb begin
        mem_we    = en & (in_clear | (wr_acc & addr_ok & ~freeze));
        mem_idx   = '0;
        mem_wdata = writedata;
        mem_be    = byteenable;
        if (in_clear) begin
            mem_idx   = fill_addr_reg[IDX_W-1:0];
            mem_wdata = '0;
            mem_be    = '1;
        end else if (addr_ok) begin
            mem_idx = address[IDX_W-1:0];
        end
    end

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_raw;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end
        end
        if (rd_acc) begin
            rd_raw <= mem[mem_idx];
        end
    end

    // zero1_reg starts set so readdata reads 0 out of reset without resetting the RAM register.
    logic              v1_reg;
    logic              zero1_reg;
    logic [DATA_W-1:0] stage1_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg    <= 1'b0;
            zero1_reg <= 1'b1;
        end else if (en) begin
            v1_reg <= rd_acc;
            if (rd_acc) begin
                zero1_reg <= ~addr_ok;
            end
        end
    end

    assign stage1_data = zero1_reg ? '0 : rd_raw;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              v2_reg;
            logic [DATA_W-1:0] data2_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v2_reg    <= 1'b0;
                    data2_reg <= '0;
                end else if (en) begin
                    v2_reg <= v1_reg;
                    if (v1_reg) begin
                        data2_reg <= stage1_data;
                    end
                end
            end

            assign readdata      = data2_reg;
            assign readdatavalid = v2_reg & en;
        end else begin : g_lat1
            assign readdata      = stage1_data;
            assign readdatavalid = v1_reg & en;
        end
    endgenerate

endmodule

// File: tb/tb_onchip_ram_avmm_param.sv
// Directed bench for onchip_ram_avmm_param: two instances (read latency 1 and 2)
// share one command stream; read results are captured with their cycle numbers.
module tb_onchip_ram_avmm_param;

    logic        clk;
    logic        rst;
    logic [4:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clken;
    logic        reset_req;
    logic        freeze;

    logic        wr1, rdv1, done1;
    logic [31:0] rd1;
    logic        wr2, rdv2, done2;
    logic [31:0] rd2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] q1_d[$];
    logic [31:0] q2_d[$];
    int          q1_c[$];
    int          q2_c[$];

    onchip_ram_avmm_param #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(1), .INIT_CLEAR(1)
    ) dut_l1 (
        .clk(clk), .reset(rst), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .waitrequest(wr1), .readdata(rd1), .readdatavalid(rdv1), .init_done(done1)
    );

    onchip_ram_avmm_param #(
        .DATA_W(32), .DEPTH(16), .ADDR_W(5), .READ_LATENCY(2), .INIT_CLEAR(1)
    ) dut_l2 (
        .clk(clk), .reset(rst), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .waitrequest(wr2), .readdata(rd2), .readdatavalid(rdv2), .init_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rdv1 === 1'b1) begin
            q1_d.push_back(rd1);
            q1_c.push_back(cyc);
        end
        if (rdv2 === 1'b1) begin
            q2_d.push_back(rd2);
            q2_c.push_back(cyc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        repeat (n) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic clear_q();
        q1_d.delete(); q1_c.delete();
        q2_d.delete(); q2_c.delete();
    endtask

    task automatic count_fill(input string name);
        int n;
        n = 0;
        while ((wr1 || wr2) && n < 100) begin
            n++;
            step();
        end
        n_tests++;
        if (n != 16) begin
            n_fail++;
            $display("FAIL %s_cycles: got %0d waitrequest cycles, expected 16", name, n);
        end
        n_tests++;
        if ({done1, done2, wr1, wr2} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s_ready: got done/wait %b, expected 1100", name, {done1, done2, wr1, wr2});
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({wr1, done1, rdv1, wr2, done2, rdv2} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset_ctrl: got wait/done/valid %b, expected 100100",
                     {wr1, done1, rdv1, wr2, done2, rdv2});
        end
        n_tests++;
        if ({rd1, rd2} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_readdata: got %h/%h, expected 0", rd1, rd2);
        end
    endtask

    task automatic test_zero_fill();
        int t;
        step();
        rst = 1'b0;
        count_fill("fill");
        clear_q();
        t = cyc;
        for (int i = 0; i < 16; i++) rd(5'(i));
        idle(4);
        n_tests++;
        if (q1_d.size() != 16 || q2_d.size() != 16) begin
            n_fail++;
            $display("FAIL fill_count: got %0d/%0d results, expected 16/16", q1_d.size(), q2_d.size());
        end
        for (int i = 0; i < q1_d.size(); i++) begin
            n_tests++;
            if (q1_d[i] !== 32'h0 || q1_c[i] != t + 1 + i) begin
                n_fail++;
                $display("FAIL fill_l1[%0d]: got %h at cycle %0d, expected 0 at %0d", i, q1_d[i], q1_c[i], t + 1 + i);
            end
        end
        for (int i = 0; i < q2_d.size(); i++) begin
            n_tests++;
            if (q2_d[i] !== 32'h0 || q2_c[i] != t + 2 + i) begin
                n_fail++;
                $display("FAIL fill_l2[%0d]: got %h at cycle %0d, expected 0 at %0d", i, q2_d[i], q2_c[i], t + 2 + i);
            end
        end
    endtask

    task automatic test_byte_enables();
        int t;
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        wr(5'd5, 32'h11223344, 4'h5);
        clear_q();
        t = cyc;
        rd(5'd5);
        idle(4);
        n_tests++;
        if (q1_d.size() != 1 || q1_d[0] !== 32'hDE22BE44 || q1_c[0] != t + 1) begin
            n_fail++;
            $display("FAIL byteen_l1: got %0d results first %h, expected 1 result DE22BE44 at %0d",
                     q1_d.size(), (q1_d.size() > 0) ? q1_d[0] : 32'hx, t + 1);
        end
        n_tests++;
        if (q2_d.size() != 1 || q2_d[0] !== 32'hDE22BE44 || q2_c[0] != t + 2) begin
            n_fail++;
            $display("FAIL byteen_l2: got %0d results first %h, expected 1 result DE22BE44 at %0d",
                     q2_d.size(), (q2_d.size() > 0) ? q2_d[0] : 32'hx, t + 2);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
        wr(5'd1, 32'hA, 4'hF);
        wr(5'd2, 32'hB, 4'hF);
        wr(5'd3, 32'hC, 4'hF);
        clear_q();
        t = cyc;
        rd(5'd1); rd(5'd2); rd(5'd3);
        idle(5);
        n_tests++;
        if (q1_d.size() != 3 || q2_d.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d/%0d results, expected 3/3", q1_d.size(), q2_d.size());
        end
        for (int i = 0; i < 3 && i < q1_d.size(); i++) begin
            n_tests++;
            if (q1_d[i] !== exp_d[i] || q1_c[i] != t + 1 + i) begin
                n_fail++;
                $display("FAIL b2b_l1[%0d]: got %h at %0d, expected %h at %0d", i, q1_d[i], q1_c[i], exp_d[i], t + 1 + i);
            end
        end
        for (int i = 0; i < 3 && i < q2_d.size(); i++) begin
            n_tests++;
            if (q2_d[i] !== exp_d[i] || q2_c[i] != t + 2 + i) begin
                n_fail++;
                $display("FAIL b2b_l2[%0d]: got %h at %0d, expected %h at %0d", i, q2_d[i], q2_c[i], exp_d[i], t + 2 + i);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) wr(5'(8 + i), 32'hC0DE0008 + 32'(i), 4'hF);
        clear_q();
        rd(5'd8);
        rd(5'd9);
        // Master keeps a read of 10 pending through the stall; it must not be taken early.
        chipselect = 1'b1; read = 1'b1; address = 5'd10;
        for (int s = 0; s < 3; s++) begin
            clken     = (s == 2);
            reset_req = (s == 2);
            @(negedge clk);
            n_tests++;
            if ({wr1, wr2, rdv1, rdv2} !== 4'b1100) begin
                n_fail++;
                $display("FAIL stall[%0d]: got wait/valid %b, expected 1100", s, {wr1, wr2, rdv1, rdv2});
            end
            @(posedge clk);
            #1;
        end
        clken = 1'b1; reset_req = 1'b0;
        step();
        rd(5'd11);
        idle(6);
        n_tests++;
        if (q1_d.size() != 4 || q2_d.size() != 4) begin
            n_fail++;
            $display("FAIL stall_count: got %0d/%0d results, expected 4/4", q1_d.size(), q2_d.size());
        end
        for (int i = 0; i < 4 && i < q1_d.size(); i++) begin
            n_tests++;
            if (q1_d[i] !== 32'hC0DE0008 + 32'(i)) begin
                n_fail++;
                $display("FAIL stall_l1[%0d]: got %h, expected %h", i, q1_d[i], 32'hC0DE0008 + 32'(i));
            end
        end
        for (int i = 0; i < 4 && i < q2_d.size(); i++) begin
            n_tests++;
            if (q2_d[i] !== 32'hC0DE0008 + 32'(i)) begin
                n_fail++;
                $display("FAIL stall_l2[%0d]: got %h, expected %h", i, q2_d[i], 32'hC0DE0008 + 32'(i));
            end
        end
    endtask

    task automatic test_freeze_range();
        int t;
        logic [31:0] exp_d [4];
        exp_d[0] = 32'h77; exp_d[1] = 32'h0; exp_d[2] = 32'h12345678; exp_d[3] = 32'h3C;
        wr(5'd7, 32'h77, 4'hF);
        freeze = 1'b1;
        wr(5'd7, 32'h55, 4'hF);
        freeze = 1'b0;
        wr(5'd0, 32'h12345678, 4'hF);
        wr(5'd16, 32'h99, 4'hF);
        clear_q();
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 5'd12; writedata = 32'h3C; byteenable = 4'hF;
        step();
        idle(4);
        n_tests++;
        if (q1_d.size() != 0 || q2_d.size() != 0) begin
            n_fail++;
            $display("FAIL rw_both_valid: got %0d/%0d results, expected 0/0", q1_d.size(), q2_d.size());
        end
        clear_q();
        t = cyc;
        rd(5'd7); rd(5'd16); rd(5'd0); rd(5'd12);
        idle(5);
        n_tests++;
        if (q1_d.size() != 4 || q2_d.size() != 4) begin
            n_fail++;
            $display("FAIL range_count: got %0d/%0d results, expected 4/4", q1_d.size(), q2_d.size());
        end
        for (int i = 0; i < 4 && i < q1_d.size(); i++) begin
            n_tests++;
            if (q1_d[i] !== exp_d[i] || q1_c[i] != t + 1 + i) begin
                n_fail++;
                $display("FAIL range_l1[%0d]: got %h at %0d, expected %h at %0d", i, q1_d[i], q1_c[i], exp_d[i], t + 1 + i);
            end
        end
        for (int i = 0; i < 4 && i < q2_d.size(); i++) begin
            n_tests++;
            if (q2_d[i] !== exp_d[i] || q2_c[i] != t + 2 + i) begin
                n_fail++;
                $display("FAIL range_l2[%0d]: got %h at %0d, expected %h at %0d", i, q2_d[i], q2_c[i], exp_d[i], t + 2 + i);
            end
        end
    endtask

    task automatic test_reset_during_fill();
        clear_q();
        rd(5'd12);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({wr1, wr2, done1, done2, rdv1, rdv2} !== 6'b110000 || {rd1, rd2} !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset: got wait/done/valid %b data %h/%h, expected 110000 and 0",
                     {wr1, wr2, done1, done2, rdv1, rdv2}, rd1, rd2);
        end
        step(); step();
        rst = 1'b0;
        repeat (8) step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({wr1, wr2, done1, done2} !== 4'b1100) begin
            n_fail++;
            $display("FAIL fill_reset: got wait/done %b, expected 1100", {wr1, wr2, done1, done2});
        end
        step(); step();
        rst = 1'b0;
        count_fill("refill");
        n_tests++;
        if (q1_d.size() != 0 || q2_d.size() != 0) begin
            n_fail++;
            $display("FAIL dropped_reads: got %0d/%0d results after reset, expected 0/0", q1_d.size(), q2_d.size());
        end
        clear_q();
        rd(5'd12);
        idle(4);
        n_tests++;
        if (q1_d.size() != 1 || q2_d.size() != 1 || q1_d[0] !== 32'h0 || q2_d[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL refill_data: got %0d/%0d results, expected one zero word each", q1_d.size(), q2_d.size());
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; byteenable = '0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0;
        clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
        test_reset();
        test_zero_fill();
        test_byte_enables();
        test_back_to_back();
        test_stall();
        test_freeze_range();
        test_reset_during_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_ram_avmm_param.md
Name: onchip_ram_avmm_param

Overview:
- Parametrised Avalon-MM single-port on-chip RAM slave. Successor to the fixed 32-bit x 38400-word Nios II program/data memory.
- Adds configurable width and depth, and selectable read latency of 1 or 2 with readdatavalid.
- Adds waitrequest flow control, a post-reset zero-fill sequencer and address range checking.
- Sits on the Qsys interconnect as a pipelined slave for the Nios II data master.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
DEPTH, 38400, number of words; need not be a power of two
ADDR_W, 16, word address width; must satisfy 2^ADDR_W >= DEPTH
READ_LATENCY, 1, cycles from read accept to readdatavalid; legal values 1 or 2
INIT_CLEAR, 1, 1 = zero-fill all words after reset; 0 = contents undefined, ready immediately

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
address  in  ADDR_W  word address
byteenable  in  DATA_W/8  byte lanes for writes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_W  write data
clken  in  1  clock enable; 0 stalls the block
reset_req  in  1  reset-pending request; treated as clken=0
freeze  in  1  write protect; writes accepted but discarded
waitrequest  out  1  request not accepted this cycle
readdata  out  DATA_W  read data
readdatavalid  out  1  readdata valid strobe
init_done  out  1  zero-fill complete / block ready

Behaviour:
- Reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values of outputs:
  - readdata = 0.
  - readdatavalid = 0.
  - init_done = !INIT_CLEAR.
  - waitrequest = INIT_CLEAR.
- Enable: en = clken & ~reset_req. When en = 0, all state holds: FSM, fill counter, read pipeline and RAM. waitrequest = 1, and readdatavalid is forced to 0 that cycle.
- FSM states:
  - CLEAR: entered on reset release when INIT_CLEAR = 1.
    - Each enabled cycle writes all-zero, all lanes, at fill_addr, then fill_addr++.
    - After DEPTH-1 is written -> READY. This takes exactly DEPTH enabled cycles.
    - waitrequest = 1 throughout.
  - READY: waitrequest = ~en. init_done = 1.
  - The FSM never returns to CLEAR except via reset.
- Accept condition: acc = chipselect & ~waitrequest.
- Write (acc & write):
  - Each byte lane i is updated only when byteenable[i] = 1.
  - Takes effect at the next clk edge.
  - Discarded when freeze = 1 or address >= DEPTH. It still completes with no stall.
- Read (acc & read & ~write):
  - RAM output is registered. readdatavalid pulses exactly READ_LATENCY enabled cycles after accept.
  - Back-to-back reads give one result per cycle, in order.
  - address >= DEPTH returns 0 with readdatavalid asserted.
- read & write both high: treated as a write only. No readdatavalid.
- Read-during-write: a read accepted the cycle after a write to the same address returns the new data. Within a single cycle only one command exists.
- readdata holds its last value when readdatavalid = 0.
- Reset mid-operation:
  - Pending reads are dropped; no readdatavalid after reset.
  - RAM contents are retained, except that CLEAR zero-fills them again when INIT_CLEAR = 1.
- Fill counter is ADDR_W wide and never exceeds DEPTH-1. No wrap past DEPTH.

Test Plan:
- Zero-fill timing:
  - Stimulus: DEPTH=16, INIT_CLEAR=1, release reset.
  - Required: waitrequest = 1 for exactly 16 cycles, then init_done = 1.
  - Then read all 16 addresses. Each returns 0x00000000.
- Byte enables:
  - Stimulus: write 0xDEADBEEF to addr 5, byteenable=0xF. Then write 0x11223344 to addr 5, byteenable=0x5.
  - Required: a read of addr 5 returns 0xDE22BE44.
- Read latency and throughput:
  - Stimulus: READ_LATENCY=2, back-to-back reads of addr 1, 2, 3 holding 0xA, 0xB, 0xC.
  - Required: readdatavalid high on cycles t+2, t+3, t+4 with data 0xA, 0xB, 0xC.
  - Repeat with READ_LATENCY=1: results on cycles t+1 to t+3.
- Stall:
  - Stimulus: drop clken for 3 cycles mid-burst.
  - Required: waitrequest = 1 during the stall, no readdatavalid, no data lost. Output order is preserved after clken returns.
- Freeze and range checks:
  - freeze=1 write of 0x55 to addr 7 -> addr 7 is unchanged.
  - Read of addr DEPTH -> 0 with readdatavalid.
  - Write to addr DEPTH -> no RAM change.
- Reset during fill:
  - Stimulus: assert reset at fill_addr=8.
  - Required: outputs return to reset values immediately, asynchronously. Fill restarts at 0 and takes the full 16 cycles.
